varint_encoder_fsm: RTL and testbench

Control FSM that encodes 32-bit unsigned words into protobuf-style varint bytes. It sits between an input data FIFO (with companion index FIFO) and an output byte FIFO (with companion index FIFO). Each word popped from the input is emitted as 1-5 bytes, least-significant 7-bit group first, with bit 7 set on every byte except the last. The last byte of each varint is marked by an output index push.

---
 rtl/varint_encoder_fsm.sv | 136 +++++++++++++
 tb/tb_varint_encoder_fsm.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/varint_encoder_fsm.sv
// Protobuf-style varint encoder control FSM: pops 32-bit words from an input FIFO
// and pushes 1-5 bytes (LS 7-bit group first) plus an end-of-varint index push.
module varint_encoder_fsm (
  input  logic        clk,
  input  logic        reset,
  input  logic        varint_in_fifo_empty,
  input  logic        varint_out_fifo_full,
  input  logic [31:0] varint_data_in,
  output logic        varint_in_fifo_pop,
  output logic        varint_in_index_pop,
  output logic        varint_out_fifo_clr,
  output logic        varint_out_fifo_push,
  output logic        varint_out_index_clr,
  output logic        varint_out_index_push,
  output logic [7:0]  varint_data_out
);

  localparam int unsigned IN_W  = 32;
  localparam int unsigned OUT_W = 8;
  localparam int unsigned GRP_W = 7;

  typedef enum logic [2:0] {
    S_INIT,
    S_V_READY,
    S_LOAD,
    S_ENCODE_L,
    S_LOAD_COND,
    S_VF_FULL
  } state_t;

  state_t             r_state;
  logic [IN_W-1:0]    r_sr;
  logic               r_done;
  logic               r_in_pop;
  logic               r_in_idx_pop;
  logic               r_out_clr;
  logic               r_out_idx_clr;
  logic               r_out_push;
  logic               r_out_idx_push;
  logic [OUT_W-1:0]   r_data_out;

  logic [IN_W-1:0]    w_enc_src;
  logic               w_enc_more;
  logic [OUT_W-1:0]   w_enc_byte;
  logic               w_sr_more;

  // Outputs are registered, so the byte for an ENCODE_L cycle is formed on the
  // edge that enters it: straight from the FIFO head when leaving LOAD.
  assign w_enc_src  = (r_state == S_LOAD) ? varint_data_in : r_sr;
  assign w_enc_more = |w_enc_src[IN_W-1:GRP_W];
  assign w_enc_byte = {w_enc_more, w_enc_src[GRP_W-1:0]};
  assign w_sr_more  = |r_sr[IN_W-1:GRP_W];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= S_INIT;
      r_sr           <= '0;
      r_done         <= 1'b0;
      r_in_pop       <= 1'b0;
      r_in_idx_pop   <= 1'b0;
      r_out_clr      <= 1'b1;
      r_out_idx_clr  <= 1'b1;
      r_out_push     <= 1'b0;
      r_out_idx_push <= 1'b0;
      r_data_out     <= '0;
    end else begin
      r_in_pop       <= 1'b0;
      r_in_idx_pop   <= 1'b0;
      r_out_clr      <= 1'b0;
      r_out_idx_clr  <= 1'b0;
      r_out_push     <= 1'b0;
      r_out_idx_push <= 1'b0;
      r_data_out     <= '0;
      case (r_state)
        S_INIT: begin
          r_state <= S_V_READY;
        end
        S_V_READY: begin
          if (!varint_in_fifo_empty) begin
            r_state      <= S_LOAD;
            r_in_pop     <= 1'b1;
            r_in_idx_pop <= 1'b1;
          end
        end
        S_LOAD: begin
          r_sr <= varint_data_in;
          if (varint_out_fifo_full) begin
            r_state <= S_VF_FULL;
          end else begin
            r_state        <= S_ENCODE_L;
            r_out_push     <= 1'b1;
            r_out_idx_push <= !w_enc_more;
            r_data_out     <= w_enc_byte;
          end
        end
        S_ENCODE_L: begin
          r_sr    <= r_sr >> GRP_W;
          r_done  <= !w_sr_more;
          r_state <= S_LOAD_COND;
        end
        S_LOAD_COND: begin
          if (r_done) begin
            r_state <= S_V_READY;
          end else if (varint_out_fifo_full) begin
            r_state <= S_VF_FULL;
          end else begin
            r_state        <= S_ENCODE_L;
            r_out_push     <= 1'b1;
            r_out_idx_push <= !w_enc_more;
            r_data_out     <= w_enc_byte;
          end
        end
        S_VF_FULL: begin
          if (!varint_out_fifo_full) begin
            r_state        <= S_ENCODE_L;
            r_out_push     <= 1'b1;
            r_out_idx_push <= !w_enc_more;
            r_data_out     <= w_enc_byte;
          end
        end
        default: begin
          r_state <= S_INIT;
        end
      endcase
    end
  end

  assign varint_in_fifo_pop    = r_in_pop;
  assign varint_in_index_pop   = r_in_idx_pop;
  assign varint_out_fifo_clr   = r_out_clr;
  assign varint_out_fifo_push  = r_out_push;
  assign varint_out_index_clr  = r_out_idx_clr;
  assign varint_out_index_push = r_out_idx_push;
  assign varint_data_out       = r_data_out;

endmodule

// File: tb/tb_varint_encoder_fsm.sv
// Bench for varint_encoder_fsm: input FIFO model, expected-byte scoreboard,
// vector table plus hand-written stall and mid-encode reset sequences.
module tb_varint_encoder_fsm;

  logic        clk = 1'b0;
  logic        reset;
  logic        varint_in_fifo_empty;
  logic        varint_out_fifo_full;
  logic [31:0] varint_data_in;
  logic        varint_in_fifo_pop;
  logic        varint_in_index_pop;
  logic        varint_out_fifo_clr;
  logic        varint_out_fifo_push;
  logic        varint_out_index_clr;
  logic        varint_out_index_push;
  logic [7:0]  varint_data_out;

  always #5 clk = ~clk;

  varint_encoder_fsm dut (
    .clk                   (clk),
    .reset                 (reset),
    .varint_in_fifo_empty  (varint_in_fifo_empty),
    .varint_out_fifo_full  (varint_out_fifo_full),
    .varint_data_in        (varint_data_in),
    .varint_in_fifo_pop    (varint_in_fifo_pop),
    .varint_in_index_pop   (varint_in_index_pop),
    .varint_out_fifo_clr   (varint_out_fifo_clr),
    .varint_out_fifo_push  (varint_out_fifo_push),
    .varint_out_index_clr  (varint_out_index_clr),
    .varint_out_index_push (varint_out_index_push),
    .varint_data_out       (varint_data_out)
  );

  typedef struct {
    logic [31:0] word;
    int          nb;
    logic [39:0] bytes;   // byte i at [8*i +: 8]
  } vec_t;

  typedef struct {
    logic [7:0] b;
    logic       last;
  } exp_t;

  localparam int NVEC = 12;

  vec_t        tbl [NVEC];
  exp_t        exp_mem [512];
  int          exp_wr, exp_rd;
  logic [31:0] in_mem [128];
  int          in_wr, in_rd;
  logic [31:0] noise;
  logic        pend_pop;
  logic        full_prev;
  int          checks, errors;
  int          cyc, n_push, n_idx, n_pops, n_idx_exp, pop_cyc, idx_cyc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic fifo_drive();
    varint_in_fifo_empty = (in_rd == in_wr);
    varint_data_in       = (in_rd == in_wr) ? noise : in_mem[in_rd];
  endtask

  task automatic send(input logic [31:0] w, input int nb, input logic [39:0] bytes);
    in_mem[in_wr] = w;
    in_wr++;
    for (int i = 0; i < nb; i++) begin
      exp_mem[exp_wr].b    = bytes[8*i +: 8];
      exp_mem[exp_wr].last = (i == nb - 1);
      exp_wr++;
    end
    n_idx_exp++;
    fifo_drive();
  endtask

  // Sample DUT outputs mid-cycle and score them.
  task automatic tick_neg();
    @(negedge clk);
    cyc++;
    if (varint_in_fifo_pop || varint_in_index_pop)
      chk("pop_pair", 32'(varint_in_index_pop), 32'(varint_in_fifo_pop));
    if (varint_in_fifo_pop) begin
      n_pops++;
      pend_pop = 1'b1;
      pop_cyc  = cyc;
    end
    if (varint_out_fifo_push) begin
      n_push++;
      chk("push_while_full", 32'(full_prev), 32'd0);
      if (exp_rd == exp_wr) begin
        checks++;
        errors++;
        $display("FAIL unexpected_push: got byte 0x%0h, required no push", varint_data_out);
      end else begin
        chk("byte", 32'(varint_data_out), 32'(exp_mem[exp_rd].b));
        chk("index_push", 32'(varint_out_index_push), 32'(exp_mem[exp_rd].last));
        exp_rd++;
      end
      if (varint_out_index_push) begin
        n_idx++;
        idx_cyc = cyc;
      end
    end else begin
      chk("idle_outputs", 32'({varint_out_index_push, varint_data_out}), 32'd0);
    end
    full_prev = varint_out_fifo_full;
  endtask

  // Advance past the active edge; a pop observed this cycle retires the head.
  task automatic tick_pos();
    @(posedge clk);
    #2;
    if (pend_pop) begin
      if (in_rd < in_wr) in_rd++;
      else begin
        checks++;
        errors++;
        $display("FAIL pop_when_empty: got pop, required none");
      end
      pend_pop = 1'b0;
    end
    fifo_drive();
  endtask

  task automatic tick();
    tick_neg();
    tick_pos();
  endtask

  task automatic drain(input bit rnd, input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (rnd) varint_out_fifo_full = ($urandom_range(0, 2) == 0);
      if (exp_rd == exp_wr && in_rd == in_wr) begin
        ok = 1'b1;
        break;
      end
    end
    varint_out_fifo_full = 1'b0;
    chk("drain_timeout", 32'(ok), 32'd1);
    repeat (3) tick();
  endtask

  initial begin
    int  start;
    bit  hit;

    tbl[0]  = '{32'hAEB48F8A, 5, 40'h0A_F5_D2_9F_8A};
    tbl[1]  = '{32'h00000000, 1, 40'h00_00_00_00_00};
    tbl[2]  = '{32'h0000007F, 1, 40'h00_00_00_00_7F};
    tbl[3]  = '{32'h00000080, 2, 40'h00_00_00_01_80};
    tbl[4]  = '{32'h00003FFF, 2, 40'h00_00_00_7F_FF};
    tbl[5]  = '{32'h00004000, 3, 40'h00_00_01_80_80};
    tbl[6]  = '{32'h001FFFFF, 3, 40'h00_00_7F_FF_FF};
    tbl[7]  = '{32'h00200000, 4, 40'h00_01_80_80_80};
    tbl[8]  = '{32'h0FFFFFFF, 4, 40'h00_7F_FF_FF_FF};
    tbl[9]  = '{32'h10000000, 5, 40'h01_80_80_80_80};
    tbl[10] = '{32'hFFFFFFFF, 5, 40'h0F_FF_FF_FF_FF};
    tbl[11] = '{32'h12345678, 5, 40'h01_91_D1_AC_F8};

    checks = 0; errors = 0; cyc = 0; n_push = 0; n_idx = 0; n_pops = 0;
    n_idx_exp = 0; pop_cyc = 0; idx_cyc = 0;
    exp_wr = 0; exp_rd = 0; in_wr = 0; in_rd = 0;
    noise = 32'd0; pend_pop = 1'b0; full_prev = 1'b0;
    reset = 1'b0;
    varint_out_fifo_full = 1'b0;
    fifo_drive();

    // Reset held two cycles, then one INIT clear cycle.
    @(posedge clk);
    #2;
    tick_neg();
    chk("rst_fifo_clr", 32'(varint_out_fifo_clr), 32'd1);
    chk("rst_index_clr", 32'(varint_out_index_clr), 32'd1);
    chk("rst_pop", 32'({varint_in_fifo_pop, varint_in_index_pop}), 32'd0);
    tick_pos();
    tick();
    reset = 1'b1;
    tick_neg();
    chk("init_fifo_clr", 32'(varint_out_fifo_clr), 32'd1);
    chk("init_index_clr", 32'(varint_out_index_clr), 32'd1);
    tick_pos();
    tick_neg();
    chk("ready_fifo_clr", 32'(varint_out_fifo_clr), 32'd0);
    chk("ready_index_clr", 32'(varint_out_index_clr), 32'd0);
    tick_pos();
    repeat (4) tick();
    chk("idle_no_pop", 32'(n_pops), 32'd0);

    // Single five-byte word, unstalled: last byte 9 cycles after LOAD.
    send(tbl[0].word, tbl[0].nb, tbl[0].bytes);
    drain(1'b0, 100);
    chk("latency_5byte", 32'(idx_cyc - pop_cyc), 32'd9);
    chk("pops_first", 32'(n_pops), 32'd1);

    // Output full after the first byte, input head changes during the stall.
    send(32'h00000081, 2, 40'h00_00_00_01_81);
    start = n_push;
    hit   = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick_neg();
      if (n_push == start + 1) begin
        hit = 1'b1;
        break;
      end
      tick_pos();
    end
    chk("stall_first_byte", 32'(hit), 32'd1);
    tick_pos();
    varint_out_fifo_full = 1'b1;
    noise = 32'h12345678;
    fifo_drive();
    tick();
    tick();
    chk("stall_no_push", 32'(n_push), 32'(start + 1));
    varint_out_fifo_full = 1'b0;
    drain(1'b0, 100);
    noise = 32'd0;
    fifo_drive();

    // Vector table, one word at a time.
    for (int i = 0; i < NVEC; i++) begin
      send(tbl[i].word, tbl[i].nb, tbl[i].bytes);
      drain(1'b0, 100);
    end

    // Same table back to back with random output-full stalls.
    for (int i = 0; i < NVEC; i++) send(tbl[i].word, tbl[i].nb, tbl[i].bytes);
    drain(1'b1, 3000);

    // Reset during the third byte of 0xFFFFFFFF; next word starts fresh.
    in_mem[in_wr] = 32'hFFFFFFFF;
    in_wr++;
    for (int i = 0; i < 3; i++) begin
      exp_mem[exp_wr].b    = 8'hFF;
      exp_mem[exp_wr].last = 1'b0;
      exp_wr++;
    end
    send(32'h00000081, 2, 40'h00_00_00_01_81);
    start = n_push;
    hit   = 1'b0;
    for (int k = 0; k < 60; k++) begin
      tick_neg();
      if (n_push == start + 3) begin
        hit = 1'b1;
        break;
      end
      tick_pos();
    end
    chk("reset_reach_byte3", 32'(hit), 32'd1);
    #1 reset = 1'b0;
    #1;
    chk("rst_mid_push", 32'({varint_out_fifo_push, varint_out_index_push}), 32'd0);
    chk("rst_mid_data", 32'(varint_data_out), 32'd0);
    chk("rst_mid_clr", 32'({varint_out_fifo_clr, varint_out_index_clr}), 32'd3);
    tick_pos();
    tick_neg();
    tick_pos();
    reset = 1'b1;
    tick_neg();
    chk("reinit_clr", 32'({varint_out_fifo_clr, varint_out_index_clr}), 32'd3);
    tick_pos();
    drain(1'b0, 100);

    chk("exp_drained", 32'(exp_wr - exp_rd), 32'd0);
    chk("index_push_count", 32'(n_idx), 32'(n_idx_exp));
    chk("pop_count", 32'(n_pops), 32'(in_wr));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
